// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both
// sides and an architectural flag register {V,N,C,Z}.
//
// Ports:
//   clk, rst              - rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   - operation handshake from the issue stage
//   op, a, b, set_flags   - opcode, operands (b doubles as shift amount),
//                           and whether this op writes the flag register
//   out_valid / out_ready - result handshake towards writeback
//   result, res_flags     - result and its {V,N,C,Z}, independent of set_flags
//   illegal               - result belongs to an opcode in the B-F range
//   flags                 - architectural flag register {V,N,C,Z}
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; a producer holding valid keeps its payload stable until the
// transfer, and ready may depend combinationally on the downstream ready.
//
// Pipeline: S1 holds the accepted operation; the ALU evaluates S1
// combinationally and the result moves into the S2 output register when S1
// advances. The flag register is written on that same edge, so flags follow
// issue order and ADC/SBC in S1 always see the carry of every older op.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       res_flags,
    output logic             illegal,
    output logic [3:0]       flags
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_PASS = 4'h8;
    localparam logic [3:0] OP_ADC  = 4'h9;
    localparam logic [3:0] OP_SBC  = 4'hA;

    localparam int               MSB      = WIDTH - 1;
    localparam logic [WIDTH-1:0] LP_WIDTH = WIDTH'(WIDTH);

    // Pipeline state
    logic             r_started;   // low during reset and the first cycle after it
    logic             r_s1_valid;
    logic [3:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_set;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_res_flags;
    logic             r_illegal;
    logic [3:0]       r_flags;

    // Datapath
    logic             w_s1_adv;
    logic             w_accept;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_sh;
    logic             w_sh_oor;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH-1:0] w_r;
    logic             w_c;
    logic             w_v;
    logic             w_ill;
    logic [3:0]       w_flags;

    assign w_s1_adv = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready = r_started && (!r_s1_valid || w_s1_adv);
    assign w_accept = in_valid && in_ready;

    // Only ADC/SBC consume the stored carry; C doubles as borrow for SBC.
    assign w_cin = ((r_s1_op == OP_ADC) || (r_s1_op == OP_SBC)) ? r_flags[1] : 1'b0;

    // One extra bit: carry-out for add, borrow (wrap into the top bit) for subtract.
    assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {{WIDTH{1'b0}}, w_cin};
    assign w_diff = {1'b0, r_s1_a} - {1'b0, r_s1_b} - {{WIDTH{1'b0}}, w_cin};

    // Shifts run on a WIDTH+1 vector so the last bit shifted out lands in the
    // extra bit; with sh==0 that bit is the zero padding, giving C=0.
    assign w_sh     = r_s1_b[SHW-1:0];
    assign w_sh_oor = (r_s1_b >= LP_WIDTH);
    assign w_shl    = {1'b0, r_s1_a} << w_sh;
    assign w_shr    = {r_s1_a, 1'b0} >> w_sh;

    always_comb begin
        w_r   = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_ill = 1'b0;
        case (r_s1_op)
            OP_ADD, OP_ADC: begin
                w_r = w_sum[MSB:0];
                w_c = w_sum[WIDTH];
                w_v = (r_s1_a[MSB] == r_s1_b[MSB]) && (w_sum[MSB] != r_s1_a[MSB]);
            end
            OP_SUB, OP_SBC: begin
                w_r = w_diff[MSB:0];
                w_c = w_diff[WIDTH];
                // Subtract adds ~b, so the operand-sign test is inverted.
                w_v = (r_s1_a[MSB] != r_s1_b[MSB]) && (w_diff[MSB] != r_s1_a[MSB]);
            end
            OP_AND:  w_r = r_s1_a & r_s1_b;
            OP_OR:   w_r = r_s1_a | r_s1_b;
            OP_XOR:  w_r = r_s1_a ^ r_s1_b;
            OP_NOT:  w_r = ~r_s1_a;
            OP_PASS: w_r = r_s1_a;
            OP_SHL: begin
                if (!w_sh_oor) begin
                    w_r = w_shl[MSB:0];
                    w_c = w_shl[WIDTH];
                end
            end
            OP_SHR: begin
                if (!w_sh_oor) begin
                    w_r = w_shr[WIDTH:1];
                    w_c = w_shr[0];
                end
            end
            default: w_ill = 1'b1;
        endcase
        w_flags = w_ill ? 4'b0000 : {w_v, w_r[MSB], w_c, (w_r == '0)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_started   <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_op     <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_set    <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_result    <= '0;
            r_res_flags <= '0;
            r_illegal   <= 1'b0;
            r_flags     <= '0;
        end else begin
            r_started <= 1'b1;

            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= op;
                r_s1_a     <= a;
                r_s1_b     <= b;
                r_s1_set   <= set_flags;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_s2_valid  <= 1'b1;
                r_result    <= w_r;
                r_res_flags <= w_flags;
                r_illegal   <= w_ill;
                if (r_s1_set && !w_ill) begin
                    r_flags <= w_flags;
                end
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign res_flags = r_res_flags;
    assign illegal   = r_illegal;
    assign flags     = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (WIDTH=8): directed table, hand-written
// backpressure/reset sequences, and randomized traffic checked against a
// plain-arithmetic reference model through an in-order scoreboard.
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         set_flags;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   res_flags;
    logic         illegal;
    logic [3:0]   flags;

    // Scoreboard entry: {arch flags after op, illegal, res_flags, result}
    logic [16:0] exp_q[$];
    logic [3:0]  m_flags;
    int          n_vec  = 0;
    int          n_fail = 0;
    bit          rand_bp = 1'b0;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sf;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[$];

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .set_flags (set_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .res_flags (res_flags),
        .illegal   (illegal),
        .flags     (flags)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic logic [16:0] ref_op(input logic [3:0] o, input logic [7:0] xa,
                                           input logic [7:0] xb, input logic sf);
        int ai, bi, cin, s, sv, r, c, v;
        logic [7:0] r8;
        logic [3:0] rf;
        logic ill;
        ai = int'(xa);
        bi = int'(xb);
        cin = int'(m_flags[1]);
        c = 0; v = 0; r = 0; ill = 1'b0;
        case (o)
            4'h0, 4'h9: begin
                if (o == 4'h0) cin = 0;
                s = ai + bi + cin;
                sv = sx(ai) + sx(bi) + cin;
                r = s % 256;
                c = (s > 255) ? 1 : 0;
                v = (sv > 127 || sv < -128) ? 1 : 0;
            end
            4'h1, 4'hA: begin
                if (o == 4'h1) cin = 0;
                s = ai - bi - cin;
                sv = sx(ai) - sx(bi) - cin;
                r = (s + 256) % 256;
                c = (s < 0) ? 1 : 0;
                v = (sv > 127 || sv < -128) ? 1 : 0;
            end
            4'h2: r = ai & bi;
            4'h3: r = ai | bi;
            4'h4: r = ai ^ bi;
            4'h5: r = 255 - ai;
            4'h8: r = ai;
            4'h6: begin
                if (bi < 8) begin
                    r = (ai * (1 << bi)) % 256;
                    c = (bi == 0) ? 0 : (ai >> (8 - bi)) % 2;
                end
            end
            4'h7: begin
                if (bi < 8) begin
                    r = ai >> bi;
                    c = (bi == 0) ? 0 : (ai >> (bi - 1)) % 2;
                end
            end
            default: ill = 1'b1;
        endcase
        r8 = r[7:0];
        rf = ill ? 4'b0000 : {v[0], r8[7], c[0], (r8 == 8'h00)};
        if (sf && !ill) m_flags = rf;
        return {m_flags, ill, rf, r8};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one op and hold it until accepted; called at posedge+1.
    task automatic issue(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                         input logic sf, input bit use_exp, input logic [16:0] e_in);
        logic [16:0] e;
        bit acc;
        bit done;
        done = 1'b0;
        in_valid = 1'b1; op = o; a = xa; b = xb; set_flags = sf;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                e = ref_op(o, xa, xb, sf);
                if (use_exp) e = e_in;
                exp_q.push_back(e);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL issue_timeout: op %0h never accepted", o);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                                input logic sf, input logic [3:0] fl, input logic ill,
                                input logic [3:0] rf, input logic [7:0] r);
        vec_t t;
        t.op = o; t.a = xa; t.b = xb; t.sf = sf;
        t.exp = {fl, ill, rf, r};
        return t;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_output: result %0h with empty queue", result);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                n_vec++;
                if ({flags, illegal, res_flags, result} !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard: got flags=%b ill=%b rf=%b res=%h expected flags=%b ill=%b rf=%b res=%h",
                             flags, illegal, res_flags, result, e[16:13], e[12], e[11:8], e[7:0]);
                end
            end
        end
    end

    // Random backpressure while enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] o;
        logic [7:0] xb;

        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; set_flags = 1'b0;
        out_ready = 1'b1; m_flags = 4'b0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_res_flags", res_flags, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_flags", flags, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_before_first_clk", in_ready, 0);
        @(posedge clk);
        #1;
        chk("in_ready_after_first_clk", in_ready, 1);

        // Single op latency: ADD 7F+01 -> 80, V=1 N=1
        issue(4'h0, 8'h7F, 8'h01, 1'b1, 1'b1, {4'b1100, 1'b0, 4'b1100, 8'h80});
        @(negedge clk);
        chk("lat_not_yet_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_out_valid", out_valid, 1);
        chk("lat_result", result, 8'h80);
        chk("lat_res_flags", res_flags, 4'b1100);
        chk("lat_flags", flags, 4'b1100);
        drain();

        // Directed table, back-to-back at full throughput
        tbl.push_back(mk(4'h0, 8'hFF, 8'h01, 1, 4'b0011, 0, 4'b0011, 8'h00)); // ADD carry
        tbl.push_back(mk(4'h9, 8'h00, 8'h00, 1, 4'b0000, 0, 4'b0000, 8'h01)); // ADC uses C
        tbl.push_back(mk(4'h1, 8'h00, 8'h01, 1, 4'b0110, 0, 4'b0110, 8'hFF)); // SUB borrow
        tbl.push_back(mk(4'hC, 8'h12, 8'h34, 1, 4'b0110, 1, 4'b0000, 8'h00)); // illegal
        tbl.push_back(mk(4'hA, 8'h05, 8'h01, 1, 4'b0000, 0, 4'b0000, 8'h03)); // SBC borrow in
        tbl.push_back(mk(4'h1, 8'h00, 8'h01, 0, 4'b0000, 0, 4'b0110, 8'hFF)); // SUB no flags
        tbl.push_back(mk(4'hA, 8'h05, 8'h01, 0, 4'b0000, 0, 4'b0000, 8'h04)); // SBC no borrow
        tbl.push_back(mk(4'h6, 8'h81, 8'h01, 0, 4'b0000, 0, 4'b0010, 8'h02)); // SHL by 1
        tbl.push_back(mk(4'h7, 8'h81, 8'h08, 0, 4'b0000, 0, 4'b0001, 8'h00)); // SHR by WIDTH
        tbl.push_back(mk(4'h6, 8'h81, 8'h00, 0, 4'b0000, 0, 4'b0100, 8'h81)); // SHL by 0
        tbl.push_back(mk(4'h7, 8'h81, 8'h01, 0, 4'b0000, 0, 4'b0010, 8'h40)); // SHR by 1
        tbl.push_back(mk(4'h2, 8'hF0, 8'h3C, 1, 4'b0000, 0, 4'b0000, 8'h30)); // AND
        tbl.push_back(mk(4'h3, 8'hF0, 8'h0C, 1, 4'b0100, 0, 4'b0100, 8'hFC)); // OR
        tbl.push_back(mk(4'h4, 8'hFF, 8'hFF, 1, 4'b0001, 0, 4'b0001, 8'h00)); // XOR
        tbl.push_back(mk(4'h5, 8'h0F, 8'h55, 1, 4'b0100, 0, 4'b0100, 8'hF0)); // NOT
        tbl.push_back(mk(4'h8, 8'h00, 8'hAA, 1, 4'b0001, 0, 4'b0001, 8'h00)); // PASS
        tbl.push_back(mk(4'h7, 8'h81, 8'h09, 1, 4'b0001, 0, 4'b0001, 8'h00)); // SHR b>WIDTH
        tbl.push_back(mk(4'h0, 8'h80, 8'h80, 1, 4'b1011, 0, 4'b1011, 8'h00)); // ADD V,C,Z
        tbl.push_back(mk(4'h1, 8'h80, 8'h01, 1, 4'b1000, 0, 4'b1000, 8'h7F)); // SUB V
        foreach (tbl[i]) issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sf, 1'b1, tbl[i].exp);
        drain();

        // Backpressure: two accepted, then stall with S2 held stable
        out_ready = 1'b0;
        issue(4'h0, 8'h01, 8'h01, 1'b1, 1'b0, '0);
        issue(4'h0, 8'h02, 8'h02, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_hold_result", result, 8'h02);
            chk("bp_hold_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin
                issue(4'h1, 8'h10, 8'h03, 1'b1, 1'b0, '0);
                issue(4'h0, 8'h7F, 8'h7F, 1'b1, 1'b0, '0);
            end
        join
        drain();
        chk("bp_final_flags", flags, 4'b1100);

        // Reset with two ops in flight
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(4'h0, 8'hFF, 8'h01, 1'b1, 1'b0, '0);
        issue(4'h0, 8'h01, 8'h01, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("inflight_flags_before_rst", flags, 4'b0011);
        chk("inflight_valid_before_rst", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", out_valid, 0);
        chk("rst_async_flags", flags, 0);
        chk("rst_async_result", result, 0);
        chk("rst_async_in_ready", in_ready, 0);
        exp_q.delete();
        m_flags = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        issue(4'h9, 8'h00, 8'h00, 1'b0, 1'b0, '0); // ADC after reset: C must be 0
        drain();

        // Randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            o = 4'($urandom_range(0, 12));
            if (o == 4'hC) o = 4'($urandom_range(11, 15));
            xb = (o == 4'h6 || o == 4'h7) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            issue(o, 8'($urandom), xb, 1'($urandom_range(0, 1)), 1'b0, '0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        chk("rand_final_flags", flags, m_flags);

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
